dispatcher: RTL and testbench
=============================

Name: dispatcher

Overview:
- Issue stage between the decoder and the execution buffers (ALU reservation station, load/store buffer).
- Latches one decoded instruction and resolves its source operands from the register file, ROB and same-cycle result broadcasts.
- Allocates the ROB tag, renames the destination register, then issues a registered one-cycle dispatch packet to the RS or the LSB.
- Stalls the decoder while the target unit or the ROB is full.

Parameters:
XLEN, 32, data width
TAG_W, 5, ROB tag width; tags are 1-based, 0 means "value ready"

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
rdy  in  1  global clock enable; no state changes when 0
wrong_commit  in  1  misprediction flush from ROB
dec_valid  in  1  decoded instruction present
dec_ready  out  1  dispatcher accepts instruction this cycle
dec_op  in  7  opcode class
dec_pc  in  XLEN  instruction PC
dec_imm  in  XLEN  immediate
dec_rs1, dec_rs2, dec_rd  in  5 each  architectural registers
dec_use_rs1, dec_use_rs2  in  1 each  operand used
dec_is_mem  in  1  route to LSB (else RS)
rf_rs1, rf_rs2  out  5 each  RF read addresses (combinational from hold register)
rf_Q1, rf_Q2  in  TAG_W each  RF rename tags
rf_V1, rf_V2  in  XLEN each  RF values
rob_q1, rob_q2  out  TAG_W each  ROB lookup tags
rob_rdy1, rob_rdy2  in  1 each  ROB entry already has its result
rob_val1, rob_val2  in  XLEN each  that result
rob_full  in  1  no free ROB entry
rob_free_tag  in  TAG_W  next tag to allocate
rs_full, lsb_full  in  1 each  target buffer full
alu_valid, lsb_valid  in  1 each  result broadcasts
alu_rob_id, lsb_rob_id  in  TAG_W each  broadcast tags
alu_res, lsb_res  in  XLEN each  broadcast data
rs_dispatch_valid, lsb_dispatch_valid  out  1 each  one-cycle issue strobes
dispatch_op, dispatch_pc, dispatch_imm, dispatch_Vi, dispatch_Vj  out  7/XLEN  issue payload
dispatch_Qi, dispatch_Qj, dispatch_rd  out  TAG_W each  source tags, allocated ROB tag
rob_alloc_valid  out  1  ROB allocation strobe (same cycle as dispatch)
rob_alloc_rd  out  5  architectural destination
rf_rename_valid  out  1  RF rename strobe
rf_rename_reg  out  5  register renamed
rf_rename_tag  out  TAG_W  new tag

Behaviour:
- Reset (rst=0, async) and wrong_commit (sync, same priority): hold_valid=0, last_valid=0, all strobes 0, all payload outputs 0.
- With rdy=0, all state holds; strobes hold their previous values.
- States:
  - EMPTY (hold_valid=0): dec_ready=1.
  - HOLD (hold_valid=1): can_issue = !rob_full && (dec_is_mem ? !lsb_full : !rs_full); dec_ready = can_issue.
- Handshake: accept on dec_valid && dec_ready. Accept and issue in the same edge refills the hold register (back-to-back, one instruction per cycle).
- Operand resolution, combinational in HOLD, priority highest first:
  1. Operand unused, or rs==0: Q=0, V=0.
  2. rs == last_rd && last_valid: take last_tag as the tag, then apply steps 4-6 to that tag.
  3. Otherwise take the tag from rf_Q: if rf_Q==0, Q=0 and V=rf_V; else continue.
  4. alu_valid && alu_rob_id == tag: Q=0, V=alu_res.
  5. lsb_valid && lsb_rob_id == tag: Q=0, V=lsb_res.
  6. rob_rdy: Q=0, V=rob_val; else Q=tag, V=0.
- Issue edge: all outputs registered; exactly one of rs_dispatch_valid / lsb_dispatch_valid=1, plus rob_alloc_valid=1; dispatch_rd=rob_free_tag.
- Rename on issue: if dec_rd≠0, rf_rename_valid=1 with reg/tag, and last_valid=1, last_rd=dec_rd, last_tag=rob_free_tag. If dec_rd==0, no rename and last_valid=0.
- The RF applies a rename one edge after the strobe; last_* covers that gap. last_valid clears after one cycle unless re-set.
- Non-issue cycles: all strobes 0; payload holds its last value.
- Latency: accept at edge E, earliest issue strobe visible after edge E+1.

Test Plan:
- Reset mid-HOLD with dec_valid=1 → strobes 0, dec_ready=1 immediately after rst deasserts.
- ADDI x1,x0,5 with rob_free_tag=3 → rs_dispatch_valid=1, Qi=0, Vi=0, imm=5, dispatch_rd=3, rename x1→3.
- Back-to-back ADD x2,x1,x1 while RF still shows x1 ready (stale) → Qi=Qj=3 via last_*; same case with alu_valid, rob_id 3, res 0x10 → Qi=0, Vi=Vj=0x10.
- LW with lsb_full=1 for 4 cycles → dec_ready=0 and no strobe; lsb_dispatch_valid pulses exactly once, one edge after lsb_full drops.
- rob_full=1 with rs_full=0 → no issue; wrong_commit in HOLD → hold dropped, no dispatch.
- rf_Q1=7 with rob_rdy1=1, rob_val1=0xABCD → Qi=0, Vi=0xABCD; SW (rd=0) → no rename, last_valid=0.

Source files
------------

// File: rtl/dispatcher_if.sv
// Decoder / regfile / ROB / execution-buffer signal bundle around the dispatcher.
// The slave modport is the dispatcher's view; master is the environment's view.
interface dispatcher_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             rdy, wrong_commit;
    logic             dec_valid, dec_ready;
    logic [6:0]       dec_op;
    logic [XLEN-1:0]  dec_pc, dec_imm;
    logic [4:0]       dec_rs1, dec_rs2, dec_rd;
    logic             dec_use_rs1, dec_use_rs2, dec_is_mem;
    logic [4:0]       rf_rs1, rf_rs2;
    logic [TAG_W-1:0] rf_Q1, rf_Q2;
    logic [XLEN-1:0]  rf_V1, rf_V2;
    logic [TAG_W-1:0] rob_q1, rob_q2;
    logic             rob_rdy1, rob_rdy2;
    logic [XLEN-1:0]  rob_val1, rob_val2;
    logic             rob_full;
    logic [TAG_W-1:0] rob_free_tag;
    logic             rs_full, lsb_full;
    logic             alu_valid, lsb_valid;
    logic [TAG_W-1:0] alu_rob_id, lsb_rob_id;
    logic [XLEN-1:0]  alu_res, lsb_res;
    logic             rs_dispatch_valid, lsb_dispatch_valid;
    logic [6:0]       dispatch_op;
    logic [XLEN-1:0]  dispatch_pc, dispatch_imm, dispatch_Vi, dispatch_Vj;
    logic [TAG_W-1:0] dispatch_Qi, dispatch_Qj, dispatch_rd;
    logic             rob_alloc_valid;
    logic [4:0]       rob_alloc_rd;
    logic             rf_rename_valid;
    logic [4:0]       rf_rename_reg;
    logic [TAG_W-1:0] rf_rename_tag;

    modport slave (
        input  rdy, wrong_commit,
        input  dec_valid, dec_op, dec_pc, dec_imm, dec_rs1, dec_rs2, dec_rd,
        input  dec_use_rs1, dec_use_rs2, dec_is_mem,
        output dec_ready,
        output rf_rs1, rf_rs2,
        input  rf_Q1, rf_Q2, rf_V1, rf_V2,
        output rob_q1, rob_q2,
        input  rob_rdy1, rob_rdy2, rob_val1, rob_val2, rob_full, rob_free_tag,
        input  rs_full, lsb_full,
        input  alu_valid, lsb_valid, alu_rob_id, lsb_rob_id, alu_res, lsb_res,
        output rs_dispatch_valid, lsb_dispatch_valid, dispatch_op, dispatch_pc,
        output dispatch_imm, dispatch_Vi, dispatch_Vj, dispatch_Qi, dispatch_Qj,
        output dispatch_rd, rob_alloc_valid, rob_alloc_rd,
        output rf_rename_valid, rf_rename_reg, rf_rename_tag
    );

    modport master (
        output rdy, wrong_commit,
        output dec_valid, dec_op, dec_pc, dec_imm, dec_rs1, dec_rs2, dec_rd,
        output dec_use_rs1, dec_use_rs2, dec_is_mem,
        input  dec_ready,
        input  rf_rs1, rf_rs2,
        output rf_Q1, rf_Q2, rf_V1, rf_V2,
        input  rob_q1, rob_q2,
        output rob_rdy1, rob_rdy2, rob_val1, rob_val2, rob_full, rob_free_tag,
        output rs_full, lsb_full,
        output alu_valid, lsb_valid, alu_rob_id, lsb_rob_id, alu_res, lsb_res,
        input  rs_dispatch_valid, lsb_dispatch_valid, dispatch_op, dispatch_pc,
        input  dispatch_imm, dispatch_Vi, dispatch_Vj, dispatch_Qi, dispatch_Qj,
        input  dispatch_rd, rob_alloc_valid, rob_alloc_rd,
        input  rf_rename_valid, rf_rename_reg, rf_rename_tag
    );
endinterface

// File: rtl/dispatcher.sv
// Issue stage: holds one decoded instruction, resolves operands (RF / ROB / broadcast),
// allocates a ROB tag, renames rd and emits a registered dispatch packet to RS or LSB.
module dispatcher #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input logic       clk,
    input logic       rst,
    dispatcher_if.slave bus
);
    typedef enum logic {S_EMPTY, S_HOLD} state_t;

    typedef struct packed {
        logic [6:0]      op;
        logic [XLEN-1:0] pc, imm;
        logic [4:0]      rs1, rs2, rd;
        logic            use1, use2, is_mem;
    } inst_t;

    typedef struct packed {
        logic             rs_v, lsb_v, alloc_v, ren_v;
        logic [6:0]       op;
        logic [XLEN-1:0]  pc, imm, vi, vj;
        logic [TAG_W-1:0] qi, qj, rd, ren_tag;
        logic [4:0]       alloc_rd, ren_reg;
    } disp_t;

    typedef struct packed {
        logic [TAG_W-1:0] q;
        logic [XLEN-1:0]  v;
    } opnd_t;

    state_t           state, state_nxt;
    inst_t            hold;
    disp_t            out_q;
    logic             last_valid;
    logic [4:0]       last_rd;
    logic [TAG_W-1:0] last_tag;
    logic             can_issue, issue, accept, dec_rdy;
    logic             fwd1, fwd2;
    logic [TAG_W-1:0] tag1, tag2;
    opnd_t            op1, op2;

    // Broadcasts beat a stale ROB lookup; a tag from last_* never falls back to the RF value.
    function automatic opnd_t resolve(input logic used, input logic [4:0] rs, input logic fwd,
                                      input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] rf_v,
                                      input logic rob_rdy, input logic [XLEN-1:0] rob_val);
        opnd_t r;
        r = '0;
        if (!used || rs == 5'd0)                            r = '0;
        else if (!fwd && tag == '0)                         r.v = rf_v;
        else if (bus.alu_valid && bus.alu_rob_id == tag)    r.v = bus.alu_res;
        else if (bus.lsb_valid && bus.lsb_rob_id == tag)    r.v = bus.lsb_res;
        else if (rob_rdy)                                   r.v = rob_val;
        else                                                r.q = tag;
        return r;
    endfunction

    assign fwd1 = last_valid && hold.rs1 == last_rd;
    assign fwd2 = last_valid && hold.rs2 == last_rd;
    assign tag1 = fwd1 ? last_tag : bus.rf_Q1;
    assign tag2 = fwd2 ? last_tag : bus.rf_Q2;
    assign op1  = resolve(hold.use1, hold.rs1, fwd1, tag1, bus.rf_V1, bus.rob_rdy1, bus.rob_val1);
    assign op2  = resolve(hold.use2, hold.rs2, fwd2, tag2, bus.rf_V2, bus.rob_rdy2, bus.rob_val2);

    assign bus.rf_rs1    = hold.rs1;
    assign bus.rf_rs2    = hold.rs2;
    assign bus.rob_q1    = tag1;
    assign bus.rob_q2    = tag2;
    assign bus.dec_ready = dec_rdy;

    always_comb begin
        can_issue = !bus.rob_full && (hold.is_mem ? !bus.lsb_full : !bus.rs_full);
        dec_rdy   = (state == S_EMPTY) ? 1'b1 : can_issue;
        issue     = bus.rdy && !bus.wrong_commit && state == S_HOLD && can_issue;
        accept    = bus.rdy && !bus.wrong_commit && bus.dec_valid && dec_rdy;
        state_nxt = state;
        if (bus.rdy) begin
            if (bus.wrong_commit) state_nxt = S_EMPTY;
            else if (accept)      state_nxt = S_HOLD;
            else if (issue)       state_nxt = S_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_EMPTY;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold       <= '0;
            out_q      <= '0;
            last_valid <= 1'b0;
            last_rd    <= '0;
            last_tag   <= '0;
        end else if (bus.rdy) begin
            if (bus.wrong_commit) begin
                hold       <= '0;
                out_q      <= '0;
                last_valid <= 1'b0;
                last_rd    <= '0;
                last_tag   <= '0;
            end else begin
                if (accept) begin
                    hold.op     <= bus.dec_op;
                    hold.pc     <= bus.dec_pc;
                    hold.imm    <= bus.dec_imm;
                    hold.rs1    <= bus.dec_rs1;
                    hold.rs2    <= bus.dec_rs2;
                    hold.rd     <= bus.dec_rd;
                    hold.use1   <= bus.dec_use_rs1;
                    hold.use2   <= bus.dec_use_rs2;
                    hold.is_mem <= bus.dec_is_mem;
                end
                out_q.rs_v    <= issue && !hold.is_mem;
                out_q.lsb_v   <= issue && hold.is_mem;
                out_q.alloc_v <= issue;
                out_q.ren_v   <= issue && hold.rd != 5'd0;
                // RF sees the rename one edge late; last_* bridges exactly that cycle.
                last_valid    <= issue && hold.rd != 5'd0;
                if (issue) begin
                    out_q.op       <= hold.op;
                    out_q.pc       <= hold.pc;
                    out_q.imm      <= hold.imm;
                    out_q.vi       <= op1.v;
                    out_q.vj       <= op2.v;
                    out_q.qi       <= op1.q;
                    out_q.qj       <= op2.q;
                    out_q.rd       <= bus.rob_free_tag;
                    out_q.alloc_rd <= hold.rd;
                    out_q.ren_reg  <= hold.rd;
                    out_q.ren_tag  <= bus.rob_free_tag;
                    last_rd        <= hold.rd;
                    last_tag       <= bus.rob_free_tag;
                end
            end
        end
    end

    assign bus.rs_dispatch_valid  = out_q.rs_v;
    assign bus.lsb_dispatch_valid = out_q.lsb_v;
    assign bus.dispatch_op        = out_q.op;
    assign bus.dispatch_pc        = out_q.pc;
    assign bus.dispatch_imm       = out_q.imm;
    assign bus.dispatch_Vi        = out_q.vi;
    assign bus.dispatch_Vj        = out_q.vj;
    assign bus.dispatch_Qi        = out_q.qi;
    assign bus.dispatch_Qj        = out_q.qj;
    assign bus.dispatch_rd        = out_q.rd;
    assign bus.rob_alloc_valid    = out_q.alloc_v;
    assign bus.rob_alloc_rd       = out_q.alloc_rd;
    assign bus.rf_rename_valid    = out_q.ren_v;
    assign bus.rf_rename_reg      = out_q.ren_reg;
    assign bus.rf_rename_tag      = out_q.ren_tag;
endmodule

// File: tb/tb_dispatcher.sv
// Directed bench for dispatcher: reset, issue, rename bypass, stalls, flush, forwarding.
module tb_dispatcher;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    dispatcher_if #(.XLEN(32), .TAG_W(5)) bus ();
    dispatcher #(.XLEN(32), .TAG_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.rdy = 1'b1;  bus.wrong_commit = 1'b0;
        bus.dec_valid = 1'b0; bus.dec_op = '0; bus.dec_pc = '0; bus.dec_imm = '0;
        bus.dec_rs1 = '0; bus.dec_rs2 = '0; bus.dec_rd = '0;
        bus.dec_use_rs1 = 1'b0; bus.dec_use_rs2 = 1'b0; bus.dec_is_mem = 1'b0;
        bus.rf_Q1 = '0; bus.rf_Q2 = '0; bus.rf_V1 = '0; bus.rf_V2 = '0;
        bus.rob_rdy1 = 1'b0; bus.rob_rdy2 = 1'b0; bus.rob_val1 = '0; bus.rob_val2 = '0;
        bus.rob_full = 1'b0; bus.rob_free_tag = 5'd1; bus.rs_full = 1'b0; bus.lsb_full = 1'b0;
        bus.alu_valid = 1'b0; bus.lsb_valid = 1'b0; bus.alu_rob_id = '0; bus.lsb_rob_id = '0;
        bus.alu_res = '0; bus.lsb_res = '0;
    endtask

    task automatic drive_inst(input logic [6:0] op, input logic [31:0] pc, input logic [31:0] imm,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic u1, input logic u2, input logic mem);
        bus.dec_valid = 1'b1; bus.dec_op = op; bus.dec_pc = pc; bus.dec_imm = imm;
        bus.dec_rs1 = rs1; bus.dec_rs2 = rs2; bus.dec_rd = rd;
        bus.dec_use_rs1 = u1; bus.dec_use_rs2 = u2; bus.dec_is_mem = mem;
    endtask

    task automatic test_reset();
        set_idle();
        tick(); tick();
        tests++; if (bus.rs_dispatch_valid !== 1'b0) begin fails++; $display("FAIL rst_rsv got %0h want 0", bus.rs_dispatch_valid); end
        tests++; if (bus.dispatch_pc !== 32'h0) begin fails++; $display("FAIL rst_pc got %0h want 0", bus.dispatch_pc); end
        rst = 1'b1;
        // park an instruction in HOLD (rs_full) then reset while dec_valid stays high
        bus.rs_full = 1'b1;
        drive_inst(7'h33, 32'h40, 32'h0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0);
        tick();
        tests++; if (bus.dec_ready !== 1'b0) begin fails++; $display("FAIL rst_hold_stall got %0h want 0", bus.dec_ready); end
        rst = 1'b0;
        #1;
        tests++; if (bus.rob_alloc_valid !== 1'b0) begin fails++; $display("FAIL rst_alloc got %0h want 0", bus.rob_alloc_valid); end
        tick();
        rst = 1'b1;
        #1;
        tests++; if (bus.dec_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got %0h want 1", bus.dec_ready); end
        set_idle();
        tick();
        tests++; if (bus.rs_dispatch_valid !== 1'b0) begin fails++; $display("FAIL rst_nodisp got %0h want 0", bus.rs_dispatch_valid); end
    endtask

    task automatic test_addi();
        set_idle();
        bus.rob_free_tag = 5'd3;
        bus.rf_Q1 = 5'd2; bus.rf_V1 = 32'h55;
        drive_inst(7'h13, 32'h100, 32'd5, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0);
        tick();
        bus.dec_valid = 1'b0;
        tests++; if (bus.rs_dispatch_valid !== 1'b0) begin fails++; $display("FAIL addi_latency got %0h want 0", bus.rs_dispatch_valid); end
        tick();
        tests++; if (bus.rs_dispatch_valid !== 1'b1 || bus.lsb_dispatch_valid !== 1'b0) begin fails++; $display("FAIL addi_strobe got rs=%0h lsb=%0h want rs=1 lsb=0", bus.rs_dispatch_valid, bus.lsb_dispatch_valid); end
        tests++; if (bus.dispatch_Qi !== 5'd0 || bus.dispatch_Vi !== 32'h0) begin fails++; $display("FAIL addi_op1 got Q=%0h V=%0h want 0/0", bus.dispatch_Qi, bus.dispatch_Vi); end
        tests++; if (bus.dispatch_imm !== 32'd5 || bus.dispatch_pc !== 32'h100 || bus.dispatch_op !== 7'h13) begin fails++; $display("FAIL addi_payload got imm=%0h pc=%0h op=%0h want 5/100/13", bus.dispatch_imm, bus.dispatch_pc, bus.dispatch_op); end
        tests++; if (bus.dispatch_rd !== 5'd3 || bus.rob_alloc_valid !== 1'b1 || bus.rob_alloc_rd !== 5'd1) begin fails++; $display("FAIL addi_alloc got rd=%0h v=%0h ard=%0h want 3/1/1", bus.dispatch_rd, bus.rob_alloc_valid, bus.rob_alloc_rd); end
        tests++; if (bus.rf_rename_valid !== 1'b1 || bus.rf_rename_reg !== 5'd1 || bus.rf_rename_tag !== 5'd3) begin fails++; $display("FAIL addi_rename got v=%0h reg=%0h tag=%0h want 1/1/3", bus.rf_rename_valid, bus.rf_rename_reg, bus.rf_rename_tag); end
        tick();
    endtask

    task automatic test_back_to_back(input bit with_alu);
        logic [4:0]  exp_q;
        logic [31:0] exp_v;
        exp_q = with_alu ? 5'd0 : 5'd3;
        exp_v = with_alu ? 32'h10 : 32'h0;
        set_idle();
        bus.rob_free_tag = 5'd3;
        drive_inst(7'h13, 32'h200, 32'd5, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0);
        tick();
        drive_inst(7'h33, 32'h204, 32'd0, 5'd1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0);
        #1;
        tests++; if (bus.dec_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready got %0h want 1", bus.dec_ready); end
        tick();
        tests++; if (bus.rs_dispatch_valid !== 1'b1 || bus.dispatch_rd !== 5'd3) begin fails++; $display("FAIL b2b_first got v=%0h rd=%0h want 1/3", bus.rs_dispatch_valid, bus.dispatch_rd); end
        bus.dec_valid = 1'b0;
        bus.rob_free_tag = 5'd4;
        bus.rf_V1 = 32'h55; bus.rf_V2 = 32'h55;
        if (with_alu) begin bus.alu_valid = 1'b1; bus.alu_rob_id = 5'd3; bus.alu_res = 32'h10; end
        #1;
        tests++; if (bus.rob_q1 !== 5'd3 || bus.rob_q2 !== 5'd3) begin fails++; $display("FAIL b2b_robq got %0h/%0h want 3/3", bus.rob_q1, bus.rob_q2); end
        tick();
        bus.alu_valid = 1'b0;
        tests++; if (bus.dispatch_Qi !== exp_q || bus.dispatch_Qj !== exp_q) begin fails++; $display("FAIL b2b_q alu=%0d got %0h/%0h want %0h", with_alu, bus.dispatch_Qi, bus.dispatch_Qj, exp_q); end
        tests++; if (bus.dispatch_Vi !== exp_v || bus.dispatch_Vj !== exp_v) begin fails++; $display("FAIL b2b_v alu=%0d got %0h/%0h want %0h", with_alu, bus.dispatch_Vi, bus.dispatch_Vj, exp_v); end
        tests++; if (bus.dispatch_rd !== 5'd4 || bus.rf_rename_reg !== 5'd2 || bus.rf_rename_tag !== 5'd4) begin fails++; $display("FAIL b2b_rename got rd=%0h reg=%0h tag=%0h want 4/2/4", bus.dispatch_rd, bus.rf_rename_reg, bus.rf_rename_tag); end
        tick();
        tests++; if (bus.rs_dispatch_valid !== 1'b0 || bus.dispatch_rd !== 5'd4) begin fails++; $display("FAIL b2b_idle got v=%0h rd=%0h want 0/4", bus.rs_dispatch_valid, bus.dispatch_rd); end
    endtask

    task automatic test_rdy_hold();
        set_idle();
        bus.rob_free_tag = 5'd2;
        drive_inst(7'h13, 32'h300, 32'd1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        bus.dec_valid = 1'b0;
        tick();
        bus.rdy = 1'b0;
        tick();
        tests++; if (bus.rs_dispatch_valid !== 1'b1) begin fails++; $display("FAIL rdy_hold got %0h want 1", bus.rs_dispatch_valid); end
        bus.rdy = 1'b1;
        tick();
        tests++; if (bus.rs_dispatch_valid !== 1'b0) begin fails++; $display("FAIL rdy_release got %0h want 0", bus.rs_dispatch_valid); end
    endtask

    task automatic test_lsb_stall();
        int pulses;
        pulses = 0;
        set_idle();
        bus.rob_free_tag = 5'd5; bus.lsb_full = 1'b1;
        bus.rf_V1 = 32'h1000;
        drive_inst(7'h03, 32'h400, 32'd8, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1);
        tick();
        bus.dec_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tests++; if (bus.dec_ready !== 1'b0 || bus.lsb_dispatch_valid !== 1'b0) begin fails++; $display("FAIL lsb_stall cyc%0d got rdy=%0h v=%0h want 0/0", i, bus.dec_ready, bus.lsb_dispatch_valid); end
            tick();
        end
        bus.lsb_full = 1'b0;
        #1;
        tests++; if (bus.dec_ready !== 1'b1) begin fails++; $display("FAIL lsb_ready got %0h want 1", bus.dec_ready); end
        tick();
        tests++; if (bus.lsb_dispatch_valid !== 1'b1 || bus.rs_dispatch_valid !== 1'b0) begin fails++; $display("FAIL lsb_issue got lsb=%0h rs=%0h want 1/0", bus.lsb_dispatch_valid, bus.rs_dispatch_valid); end
        tests++; if (bus.dispatch_Vi !== 32'h1000 || bus.dispatch_Qi !== 5'd0 || bus.dispatch_rd !== 5'd5) begin fails++; $display("FAIL lsb_payload got Vi=%0h Qi=%0h rd=%0h want 1000/0/5", bus.dispatch_Vi, bus.dispatch_Qi, bus.dispatch_rd); end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.lsb_dispatch_valid === 1'b1) pulses++;
        end
        tests++; if (pulses !== 0) begin fails++; $display("FAIL lsb_once got %0d extra pulses want 0", pulses); end
    endtask

    task automatic test_rob_full_flush();
        set_idle();
        bus.rob_full = 1'b1;
        drive_inst(7'h33, 32'h500, 32'd0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0);
        tick();
        bus.dec_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tests++; if (bus.dec_ready !== 1'b0 || bus.rs_dispatch_valid !== 1'b0 || bus.rob_alloc_valid !== 1'b0) begin fails++; $display("FAIL robfull cyc%0d got rdy=%0h rs=%0h al=%0h want 0/0/0", i, bus.dec_ready, bus.rs_dispatch_valid, bus.rob_alloc_valid); end
            tick();
        end
        bus.wrong_commit = 1'b1;
        tick();
        bus.wrong_commit = 1'b0;
        #1;
        tests++; if (bus.dec_ready !== 1'b1) begin fails++; $display("FAIL flush_empty got %0h want 1", bus.dec_ready); end
        tests++; if (bus.dispatch_rd !== 5'd0 || bus.dispatch_Vi !== 32'h0) begin fails++; $display("FAIL flush_payload got rd=%0h Vi=%0h want 0/0", bus.dispatch_rd, bus.dispatch_Vi); end
        bus.rob_full = 1'b0;
        tick();
        tests++; if (bus.rs_dispatch_valid !== 1'b0) begin fails++; $display("FAIL flush_nodisp got %0h want 0", bus.rs_dispatch_valid); end
    endtask

    task automatic test_rob_fwd();
        logic [1:0]  sel [3];
        logic [4:0]  eq  [3];
        logic [31:0] ev  [3];
        sel[0] = 2'b01; eq[0] = 5'd0; ev[0] = 32'hABCD;
        sel[1] = 2'b10; eq[1] = 5'd0; ev[1] = 32'h77;
        sel[2] = 2'b00; eq[2] = 5'd7; ev[2] = 32'h0;
        for (int k = 0; k < 3; k++) begin
            set_idle();
            bus.rob_free_tag = 5'd8;
            bus.rf_Q1 = 5'd7; bus.rf_Q2 = 5'd2; bus.rf_V2 = 32'h99;
            bus.rob_val1 = 32'hABCD; bus.lsb_rob_id = 5'd7; bus.lsb_res = 32'h77;
            drive_inst(7'h33, 32'h600, 32'd0, 5'd3, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0);
            tick();
            bus.dec_valid = 1'b0;
            bus.rob_rdy1 = sel[k][0]; bus.lsb_valid = sel[k][1];
            tests++; if (bus.rob_q1 !== 5'd7) begin fails++; $display("FAIL fwd_robq case%0d got %0h want 7", k, bus.rob_q1); end
            tick();
            tests++; if (bus.dispatch_Qi !== eq[k] || bus.dispatch_Vi !== ev[k]) begin fails++; $display("FAIL fwd_op1 case%0d got Q=%0h V=%0h want %0h/%0h", k, bus.dispatch_Qi, bus.dispatch_Vi, eq[k], ev[k]); end
            tests++; if (bus.dispatch_Qj !== 5'd0 || bus.dispatch_Vj !== 32'h0) begin fails++; $display("FAIL fwd_x0 case%0d got Q=%0h V=%0h want 0/0", k, bus.dispatch_Qj, bus.dispatch_Vj); end
            bus.lsb_valid = 1'b0; bus.rob_rdy1 = 1'b0;
            tick();
        end
    endtask

    task automatic test_store_no_rename();
        set_idle();
        bus.rob_free_tag = 5'd10;
        drive_inst(7'h13, 32'h700, 32'd1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        drive_inst(7'h23, 32'h704, 32'd4, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
        tick();
        bus.rob_free_tag = 5'd11;
        drive_inst(7'h33, 32'h708, 32'd0, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
        tick();
        tests++; if (bus.lsb_dispatch_valid !== 1'b1 || bus.rob_alloc_valid !== 1'b1 || bus.dispatch_rd !== 5'd11) begin fails++; $display("FAIL sw_issue got v=%0h al=%0h rd=%0h want 1/1/b", bus.lsb_dispatch_valid, bus.rob_alloc_valid, bus.dispatch_rd); end
        tests++; if (bus.rf_rename_valid !== 1'b0 || bus.rob_alloc_rd !== 5'd0) begin fails++; $display("FAIL sw_norename got v=%0h ard=%0h want 0/0", bus.rf_rename_valid, bus.rob_alloc_rd); end
        bus.dec_valid = 1'b0;
        bus.rob_free_tag = 5'd12;
        bus.rf_Q1 = 5'd12;
        #1;
        tests++; if (bus.rob_q1 !== 5'd12) begin fails++; $display("FAIL sw_lastclr got %0h want c", bus.rob_q1); end
        tick();
        tests++; if (bus.dispatch_Qi !== 5'd12 || bus.rs_dispatch_valid !== 1'b1) begin fails++; $display("FAIL sw_after got Qi=%0h v=%0h want c/1", bus.dispatch_Qi, bus.rs_dispatch_valid); end
        tick();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back(1'b0);
        test_back_to_back(1'b1);
        test_rdy_hold();
        test_lsb_stall();
        test_rob_full_flush();
        test_rob_fwd();
        test_store_no_rename();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
